// File: rtl/pipe_stage_buf_pkg.sv
// Shared ID->EX pipeline definitions: stage-buffer state encoding and
// the payload field layout carried between decode and execute.
package pipe_stage_buf_pkg;

  // Buffer state doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_t;

  // ID->EX payload field widths.
  localparam int CTRL_W = 8;
  localparam int PC_W   = 16;
  localparam int OPA_W  = 32;
  localparam int OPB_W  = 32;
  localparam int IMM_W  = 21;
  localparam int DEST_W = 5;

  // Field offsets, LSB first: dest at bit 0, ctrl in the top bits.
  localparam int DEST_LSB = 0;
  localparam int IMM_LSB  = DEST_LSB + DEST_W;
  localparam int OPB_LSB  = IMM_LSB + IMM_W;
  localparam int OPA_LSB  = OPB_LSB + OPB_W;
  localparam int PC_LSB   = OPA_LSB + OPA_W;
  localparam int CTRL_LSB = PC_LSB + PC_W;

  // Total payload width (114).
  localparam int ID_EX_W = CTRL_LSB + CTRL_W;

endpackage

// File: rtl/pipe_stage_buf_entry.sv
// One payload slot of the stage buffer: async-reset register with a
// synchronous clear that wins over load.
module pipe_entry_reg #(
  parameter int WIDTH = 114
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear has priority so a flush cannot be undone by a same-cycle load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= '0;
    else if (clr)  q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry elastic ID->EX stage register (skid buffer). Ready and valid
// are decoded from registered state only, so there is no combinational
// path between the upstream and downstream handshakes.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int WIDTH          = ID_EX_W,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  buf_state_t       state, state_nxt;
  logic             push, pop;
  logic             head_ld, tail_ld, ent_clr;
  logic [WIDTH-1:0] head_d, head_q, tail_q;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign occupancy = state;
  assign out_data  = head_q;

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign ent_clr = flush && (CLEAR_ON_FLUSH != 0);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_EMPTY;
    else      state <= state_nxt;
  end

  // Next state and entry load controls; flush overrides push and pop.
  always_comb begin
    state_nxt = state;
    head_ld   = 1'b0;
    tail_ld   = 1'b0;
    // Only a pop out of FULL refills the head from the tail.
    head_d    = (state == ST_FULL) ? tail_q : in_data;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (push) begin
            head_ld   = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_ld = 1'b1;
          end else if (push) begin
            tail_ld   = 1'b1;
            state_nxt = ST_FULL;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            head_ld   = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.WIDTH(WIDTH)) u_head (
    .clk  (clk),
    .rst  (rst),
    .clr  (ent_clr),
    .load (head_ld),
    .d    (head_d),
    .q    (head_q)
  );

  pipe_entry_reg #(.WIDTH(WIDTH)) u_tail (
    .clk  (clk),
    .rst  (rst),
    .clr  (ent_clr),
    .load (tail_ld),
    .d    (in_data),
    .q    (tail_q)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed vector table, hand-written corner
// sequences and random traffic, all backed by a FIFO scoreboard.
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int W = ID_EX_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int errs   = 0;
  int checks = 0;
  int n_pop  = 0;

  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .CLEAR_ON_FLUSH(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  typedef struct {
    logic         iv;
    logic         ordy;
    logic         fl;
    logic [W-1:0] d;
    logic [1:0]   occ;
    logic         ov;
    logic [W-1:0] od;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge, when the inputs for
  // the coming rising edge and the outputs of the previous one are stable.
  task automatic mon_loop();
    logic         hold = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic [W-1:0] e;
    forever begin
      @(negedge clk or negedge rst);
      if (!rst) begin
        sb.delete();
        hold = 1'b0;
      end else if (!clk) begin
        chk("mon_occ", occupancy, sb.size());
        chk("mon_out_valid", out_valid, sb.size() != 0);
        chk("mon_in_ready", in_ready, sb.size() != 2);
        if (hold) begin
          chk("mon_stall_data", out_data, hold_d);
          chk("mon_stall_valid", out_valid, 1);
        end
        hold   = out_valid && !out_ready && !flush;
        hold_d = out_data;
        if (flush) begin
          sb.delete();
        end else begin
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              chk("mon_pop_empty", 1, 0);
            end else begin
              e = sb.pop_front();
              chk("mon_order", out_data, e);
              n_pop++;
            end
          end
          if (in_valid && in_ready) sb.push_back(in_data);
        end
      end
    end
  endtask

  task automatic step(input logic iv, input logic ordy, input logic fl, input logic [W-1:0] d);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    in_data   = d;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [127:0] r;
    int           p0;
    int           k;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    fork mon_loop(); join_none

    // Reset held low for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_occ", occupancy, 0);
    chk("idle_out_data", out_data, 0);

    // Directed vectors: inputs for one edge, then state after that edge.
    //              iv  ordy fl  d       occ ov  od
    tbl[0]  = '{1'b1, 1'b1, 1'b0, W'('hA5), 2'd1, 1'b1, W'('hA5)};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, W'('h00), 2'd0, 1'b0, W'('hA5)};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, W'('h11), 2'd1, 1'b1, W'('h11)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, W'('h22), 2'd2, 1'b1, W'('h11)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, W'('h33), 2'd2, 1'b1, W'('h11)};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, W'('h33), 2'd1, 1'b1, W'('h22)};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, W'('h33), 2'd1, 1'b1, W'('h33)};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, W'('h00), 2'd0, 1'b0, W'('h33)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, W'('h01), 2'd1, 1'b1, W'('h01)};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, W'('h02), 2'd1, 1'b1, W'('h02)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, W'('h03), 2'd2, 1'b1, W'('h02)};
    tbl[11] = '{1'b1, 1'b1, 1'b1, W'('h44), 2'd0, 1'b0, W'('h00)};
    tbl[12] = '{1'b0, 1'b1, 1'b0, W'('h00), 2'd0, 1'b0, W'('h00)};
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].d);
      chk($sformatf("vec%0d_occ", i), occupancy, tbl[i].occ);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].occ != 2'd2);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
    end

    // Ten back-to-back pushes with the consumer always ready.
    p0 = n_pop;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0, W'(32'h100 + i));
      chk("stream_occ_lt2", occupancy == 2'd2, 0);
    end
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("stream_pops", n_pop - p0, 10);

    // Asynchronous reset in the middle of a cycle while FULL.
    step(1'b1, 1'b0, 1'b0, W'('h55));
    step(1'b1, 1'b0, 1'b0, W'('h66));
    chk("pre_arst_occ", occupancy, 2);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_occ", occupancy, 0);
    chk("arst_out_data", out_data, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0, W'('h77));
    chk("post_arst_occ", occupancy, 1);
    chk("post_arst_out_data", out_data, W'('h77));

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 63) == 0, r[W-1:0]);
    end

    // Drain with a bounded wait.
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    k = 0;
    while (occupancy != 2'd0 && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    chk("drain_occ", occupancy, 0);
    @(negedge clk); #1;
    chk("drain_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
